// File: rtl/rc4_core_scheduler.sv
// Hands candidate keys from a shared keyspace counter to a bank of RC4 cores.
// It tracks which cores are busy, stops all cores on a verified key and reports when the keyspace is used up.
module rc4_core_scheduler #(
  parameter int               NUM_CORES = 2,
  parameter int               KEY_W     = 22,
  parameter logic [KEY_W-1:0] KEY_BASE  = 22'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX   = 22'h3FFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_valid,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_abort,
  output logic [KEY_W-1:0]           cur_key,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       exhausted,
  output logic                       busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_t;

  state_t                     state_r, state_s;
  logic [NUM_CORES-1:0]       busy_vec_r, busy_vec_s;
  logic [NUM_CORES-1:0]       done_s, match_s, win_s, disp_s;
  logic [KEY_W-1:0]           win_key_s;
  logic [NUM_CORES-1:0]       core_start_r;
  logic [NUM_CORES*KEY_W-1:0] core_key_r;
  logic                       core_abort_r, found_r, exhausted_r, busy_r;
  logic [KEY_W-1:0]           cur_key_r, found_key_r;

  // One-hot of the lowest set bit; it is used both for idle-core selection and for match priority.
  function automatic logic [NUM_CORES-1:0] lowest_one(input logic [NUM_CORES-1:0] v);
    logic [NUM_CORES-1:0] r;
    logic                 seen;
    r    = '0;
    seen = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      r[i] = v[i] & ~seen;
      seen = seen | v[i];
    end
    return r;
  endfunction

  // Next-state, dispatch selection and busy-vector update.
  always_comb begin
    done_s    = core_done & busy_vec_r;
    match_s   = done_s & core_valid;
    win_s     = lowest_one(match_s);
    win_key_s = '0;
    disp_s    = '0;
    state_s   = state_r;
    for (int i = 0; i < NUM_CORES; i++) begin
      win_key_s = win_key_s | (core_key_r[i*KEY_W +: KEY_W] & {KEY_W{win_s[i]}});
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (|match_s) begin
          state_s = ST_FOUND;
        end else begin
          // Cores finishing at this edge are not yet eligible for another key.
          disp_s = lowest_one(~busy_vec_r);
          if ((|disp_s) && (cur_key_r == KEY_MAX)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        if (|match_s) begin
          state_s = ST_FOUND;
        end else if (busy_vec_r == '0) begin
          state_s = ST_EXHAUSTED;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_FOUND:     state_s = ST_FOUND;
      ST_EXHAUSTED: state_s = ST_EXHAUSTED;
      default:      state_s = ST_IDLE;
    endcase
    if (|match_s) begin
      busy_vec_s = '0;
    end else begin
      busy_vec_s = (busy_vec_r & ~done_s) | disp_s;
    end
  end

  // State, keyspace counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_vec_r   <= '0;
      core_start_r <= '0;
      core_key_r   <= '0;
      core_abort_r <= 1'b0;
      cur_key_r    <= KEY_BASE;
      found_r      <= 1'b0;
      found_key_r  <= '0;
      exhausted_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      busy_vec_r   <= busy_vec_s;
      core_start_r <= disp_s;
      core_abort_r <= |match_s;
      found_r      <= found_r | (|match_s);
      exhausted_r  <= (state_s == ST_EXHAUSTED);
      busy_r       <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      if (|match_s) begin
        found_key_r <= win_key_s;
      end
      // Saturate at KEY_MAX so the counter never wraps or goes past the end.
      if ((|disp_s) && (cur_key_r != KEY_MAX)) begin
        cur_key_r <= cur_key_r + KEY_W'(1);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (disp_s[i]) begin
          core_key_r[i*KEY_W +: KEY_W] <= cur_key_r;
        end
      end
    end
  end

  assign core_start = core_start_r;
  assign core_key   = core_key_r;
  assign core_abort = core_abort_r;
  assign cur_key    = cur_key_r;
  assign found      = found_r;
  assign found_key  = found_key_r;
  assign exhausted  = exhausted_r;
  assign busy       = busy_r;

endmodule
